// File: rtl/dcache_stage1_pkg.sv
// dcache_stage1_pkg: shared geometry, FSM encoding and way-select helper for the dcache lookup stage.
package dcache_stage1_pkg;
  localparam int WAYS_N = 4;
  localparam int SETS_N = 128;
  localparam int TAG_W = 20;
  localparam int IDX_W = 7;
  localparam int OFF_W = 5;
  localparam int WAY_W = 2;
  localparam int LINE_W = 256;
  typedef enum logic [1:0] {IDLE, LOOKUP, EVICT, ALLOC} state_t;
  function automatic logic [WAY_W-1:0] first_way(input logic [WAYS_N-1:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/dcache_plru.sv
// dcache_plru: per-set 3-bit tree pseudo-LRU with a read port for victim choice and a write port for touches.
module dcache_plru
  import dcache_stage1_pkg::*;
#(
  parameter int SETS = SETS_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  output logic [WAY_W-1:0] rd_way,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [WAY_W-1:0] wr_way
);
  logic [2:0] tree [SETS];
  logic [2:0] rd, cur, upd;
  assign rd = tree[rd_index];
  assign cur = tree[wr_index];
  assign rd_way = rd[0] ? {1'b1, rd[2]} : {1'b0, rd[1]};
  // b0 points away from the touched half, the half's own bit away from the touched way
  assign upd = {wr_way[1] ? ~wr_way[0] : cur[2], wr_way[1] ? cur[1] : ~wr_way[0], ~wr_way[1]};
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < SETS; i++) tree[i] <= '0;
    else if (wr_en) tree[wr_index] <= upd;
endmodule

// File: rtl/dcache_stage1.sv
// dcache_stage1: tag lookup, hit report, victim selection, writeback push and MSHR allocation.
module dcache_stage1
  import dcache_stage1_pkg::*;
#(
  parameter int WAYS = WAYS_N,
  parameter int SETS = SETS_N
) (
  input  logic                     Clk,
  input  logic                     Rest,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     ReqLoad,
  input  logic                     ReqStore,
  input  logic [31:0]              ReqAddr,
  input  logic [31:0]              ReqStoreData,
  input  logic [2:0]               ReqPtr,
  output logic                     TagReadAble,
  output logic [IDX_W-1:0]         TagReadIndex,
  input  logic [WAYS*TAG_W-1:0]    TagRdTag,
  input  logic [WAYS-1:0]          TagRdValid,
  input  logic [WAYS-1:0]          TagRdDirty,
  input  logic [WAYS*LINE_W-1:0]   LineRdData,
  output logic                     HitAble,
  output logic [WAYS-1:0]          HitWay,
  output logic [IDX_W-1:0]         HitIndex,
  output logic                     HitLoad,
  output logic                     HitStore,
  output logic [2:0]               HitPtr,
  output logic                     WriteBuffAble,
  output logic [31:0]              WriteBuffAddr,
  output logic [LINE_W-1:0]        WriteBackDate,
  output logic [7:0]               WriteBackCnt,
  input  logic                     WriteBuffFull,
  output logic                     MSHRAble,
  output logic [31:0]              MSHRAddr,
  output logic                     MSHRLoad,
  output logic                     MSHRStore,
  output logic [31:0]              MSHRStoreTemp,
  output logic [WAYS-1:0]          MSHRWay,
  output logic [2:0]               MSHRPtr,
  input  logic                     MSHRFull
);
  state_t state, next;
  logic ld_q, st_q, hit_fire, wb_fire, ms_fire, unused;
  logic [31:OFF_W] addr_q;
  logic [31:0] data_q;
  logic [2:0] ptr_q;
  logic [IDX_W-1:0] idx;
  logic [WAY_W-1:0] vway_q, hway, vic, plru_way;
  logic [TAG_W-1:0] vtag_q;
  logic [LINE_W-1:0] vline_q;
  logic [WAYS-1:0] hits;
  assign unused = ^ReqAddr[OFF_W-1:0];
  assign idx = addr_q[OFF_W +: IDX_W];
  assign ReqReady = (state == IDLE) | Rest;
  assign TagReadAble = ReqValid & (state == IDLE) & ~Rest;
  assign TagReadIndex = TagReadAble ? ReqAddr[OFF_W +: IDX_W] : '0;
  for (genvar w = 0; w < WAYS; w++)
    assign hits[w] = TagRdValid[w] & (TagRdTag[w*TAG_W +: TAG_W] == addr_q[31 -: TAG_W]);
  assign hway = first_way(hits);
  assign vic = &TagRdValid ? plru_way : first_way(~TagRdValid);
  assign hit_fire = (state == LOOKUP) & (ld_q | st_q) & |hits;
  assign wb_fire = (state == EVICT) & ~WriteBuffFull;
  assign ms_fire = (state == ALLOC) & ~MSHRFull;
  always_comb begin
    next = state;
    next = state == IDLE ? (ReqValid ? LOOKUP : IDLE)
         : state == LOOKUP ? (~(ld_q | st_q) | |hits ? IDLE
                             : TagRdValid[vic] & TagRdDirty[vic] ? EVICT : ALLOC)
         : state == EVICT ? (WriteBuffFull ? EVICT : ALLOC)
         : (MSHRFull ? ALLOC : IDLE);
  end
  dcache_plru #(.SETS(SETS)) u_plru (
    .clk(Clk), .rst(Rest), .rd_index(idx), .rd_way(plru_way),
    .wr_en(hit_fire | ms_fire), .wr_index(idx), .wr_way(hit_fire ? hway : vway_q)
  );
  always_ff @(posedge Clk) begin
    if (TagReadAble) {ld_q, st_q, addr_q, data_q, ptr_q} <= {ReqLoad, ReqStore, ReqAddr[31:OFF_W], ReqStoreData, ReqPtr};
    if (state == LOOKUP) begin
      vway_q <= vic;
      vtag_q <= TagRdTag[vic*TAG_W +: TAG_W];
      vline_q <= LineRdData[vic*LINE_W +: LINE_W];
    end
  end
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state <= IDLE;
      {HitAble, HitWay, HitIndex, HitLoad, HitStore, HitPtr} <= '0;
      {WriteBuffAble, WriteBuffAddr, WriteBackDate, WriteBackCnt} <= '0;
      {MSHRAble, MSHRAddr, MSHRLoad, MSHRStore, MSHRStoreTemp, MSHRWay, MSHRPtr} <= '0;
    end else begin
      state <= next;
      HitAble <= hit_fire;
      WriteBuffAble <= wb_fire;
      MSHRAble <= ms_fire;
      if (hit_fire) {HitWay, HitIndex, HitLoad, HitStore, HitPtr} <= {WAYS'(1) << hway, idx, ld_q, st_q, ptr_q};
      if (wb_fire) {WriteBuffAddr, WriteBackDate, WriteBackCnt} <= {vtag_q, idx, {OFF_W{1'b0}}, vline_q, 8'hFF};
      if (ms_fire) begin
        MSHRAddr <= {addr_q, {OFF_W{1'b0}}};
        {MSHRLoad, MSHRStore, MSHRStoreTemp, MSHRPtr} <= {ld_q, st_q, data_q, ptr_q};
        MSHRWay <= WAYS'(1) << vway_q;
      end
    end
  end
endmodule

// File: tb/tb_dcache_stage1.sv
// tb_dcache_stage1: random and directed requests scored against a cache-contents and MRU-tree model.
module tb_dcache_stage1;
  logic Clk = 0, Rest = 1;
  logic ReqValid = 0, ReqReady, ReqLoad = 0, ReqStore = 0;
  logic [31:0] ReqAddr = 0, ReqStoreData = 0;
  logic [2:0] ReqPtr = 0;
  logic TagReadAble;
  logic [6:0] TagReadIndex;
  logic [79:0] TagRdTag = 0;
  logic [3:0] TagRdValid = 0, TagRdDirty = 0;
  logic [1023:0] LineRdData = 0;
  logic HitAble, HitLoad, HitStore;
  logic [3:0] HitWay;
  logic [6:0] HitIndex;
  logic [2:0] HitPtr;
  logic WriteBuffAble, WriteBuffFull = 0;
  logic [31:0] WriteBuffAddr;
  logic [255:0] WriteBackDate;
  logic [7:0] WriteBackCnt;
  logic MSHRAble, MSHRLoad, MSHRStore, MSHRFull = 0;
  logic [31:0] MSHRAddr, MSHRStoreTemp;
  logic [3:0] MSHRWay;
  logic [2:0] MSHRPtr;

  always #5 Clk = ~Clk;

  dcache_stage1 dut (
    .Clk(Clk), .Rest(Rest), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqLoad(ReqLoad),
    .ReqStore(ReqStore), .ReqAddr(ReqAddr), .ReqStoreData(ReqStoreData), .ReqPtr(ReqPtr),
    .TagReadAble(TagReadAble), .TagReadIndex(TagReadIndex), .TagRdTag(TagRdTag),
    .TagRdValid(TagRdValid), .TagRdDirty(TagRdDirty), .LineRdData(LineRdData),
    .HitAble(HitAble), .HitWay(HitWay), .HitIndex(HitIndex), .HitLoad(HitLoad),
    .HitStore(HitStore), .HitPtr(HitPtr), .WriteBuffAble(WriteBuffAble),
    .WriteBuffAddr(WriteBuffAddr), .WriteBackDate(WriteBackDate), .WriteBackCnt(WriteBackCnt),
    .WriteBuffFull(WriteBuffFull), .MSHRAble(MSHRAble), .MSHRAddr(MSHRAddr),
    .MSHRLoad(MSHRLoad), .MSHRStore(MSHRStore), .MSHRStoreTemp(MSHRStoreTemp),
    .MSHRWay(MSHRWay), .MSHRPtr(MSHRPtr), .MSHRFull(MSHRFull)
  );

  int n_chk = 0, n_fail = 0;
  logic [19:0] m_tag [128][4];
  bit m_val [128][4], m_dirty [128][4];
  logic [255:0] m_line [128][4];
  bit last_low [128];
  int mru_low [128], mru_high [128];
  logic [3:0] obs_mway;
  logic [19:0] pool [6];
  int sets [4] = '{3, 17, 64, 127};
  logic [3:0] seq [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rline();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // reset tree = "high half touched last, way1 and way3 most recent in their halves"
  task automatic plru_reset();
    for (int s = 0; s < 128; s++) begin
      last_low[s] = 0;
      mru_low[s] = 1;
      mru_high[s] = 3;
    end
  endtask

  task automatic touch(input int s, input int w);
    if (w < 2) begin
      last_low[s] = 1;
      mru_low[s] = w;
    end else begin
      last_low[s] = 0;
      mru_high[s] = w;
    end
  endtask

  function automatic int model_victim(input int s);
    for (int w = 0; w < 4; w++) if (!m_val[s][w]) return w;
    return last_low[s] ? 5 - mru_high[s] : 1 - mru_low[s];
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Rest = 1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Rest = 0;
    plru_reset();
  endtask

  task automatic drive_tags(input int s);
    for (int w = 0; w < 4; w++) begin
      TagRdTag[w*20 +: 20] = m_tag[s][w];
      TagRdValid[w] = m_val[s][w];
      TagRdDirty[w] = m_dirty[s][w];
      LineRdData[w*256 +: 256] = m_line[s][w];
    end
  endtask

  task automatic do_req(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] p, input int wbf, input int msf, input int rst_at);
    int s, hw, vw, hit_k, wb_k, ms_k, done, astart;
    bit ev;
    logic [19:0] t;
    s = int'(a[11:5]);
    t = a[31:12];
    hw = -1;
    for (int w = 0; w < 4; w++) if (hw < 0 && m_val[s][w] && m_tag[s][w] == t) hw = w;
    vw = model_victim(s);
    ev = hw < 0 && m_val[s][vw] && m_dirty[s][vw];
    hit_k = 0; wb_k = 0; ms_k = 0; done = 2; astart = 2;
    if ((ld || st) && hw >= 0) hit_k = 2;
    else if (ld || st) begin
      astart = ev ? 3 + wbf : 2;
      if (ev) wb_k = 3 + wbf;
      ms_k = astart + msf + 1;
      done = ms_k;
    end
    if (rst_at > 0) begin
      hit_k = 0; wb_k = 0; ms_k = 0; done = rst_at + 1;
    end
    @(negedge Clk);
    {ReqValid, ReqLoad, ReqStore, ReqAddr, ReqStoreData, ReqPtr} = {1'b1, ld, st, a, d, p};
    #1;
    check("req_ready", ReqReady, 1);
    check("tag_read", TagReadAble, 1);
    check("tag_index", TagReadIndex, a[11:5]);
    @(posedge Clk);
    #1;
    ReqValid = 0;
    ReqAddr = $urandom;
    ReqStoreData = $urandom;
    drive_tags(s);
    for (int k = 1; k <= done + 2; k++) begin
      if (k > 1) begin
        @(posedge Clk);
        #1;
      end
      if (k == 2) begin
        TagRdTag = {$urandom, $urandom, $urandom};
        TagRdValid = 4'($urandom);
        TagRdDirty = 4'($urandom);
        LineRdData = {4{rline()}};
      end
      WriteBuffFull = k < 2 + wbf;
      MSHRFull = k < astart + msf;
      if (rst_at > 0) Rest = k == rst_at;
      @(negedge Clk);
      check("hit_pulse", HitAble, k == hit_k);
      check("wb_pulse", WriteBuffAble, k == wb_k);
      check("mshr_pulse", MSHRAble, k == ms_k);
      if (k != rst_at) check("ready_busy", ReqReady, k >= done);
      if (k == hit_k) begin
        check("hit_way", HitWay, 4'b0001 << hw);
        check("hit_index", HitIndex, a[11:5]);
        check("hit_kind", {HitLoad, HitStore, HitPtr}, {ld, st, p});
      end
      if (k == wb_k) begin
        check("wb_addr", WriteBuffAddr, {m_tag[s][vw], a[11:5], 5'b0});
        check("wb_data", WriteBackDate, m_line[s][vw]);
        check("wb_cnt", WriteBackCnt, 8'hFF);
      end
      if (k == ms_k) begin
        obs_mway = MSHRWay;
        check("mshr_addr", MSHRAddr, {a[31:5], 5'b0});
        check("mshr_way", MSHRWay, 4'b0001 << vw);
        check("mshr_kind", {MSHRLoad, MSHRStore, MSHRPtr}, {ld, st, p});
        check("mshr_data", MSHRStoreTemp, d);
      end
    end
    WriteBuffFull = 0;
    MSHRFull = 0;
    Rest = 0;
    if (rst_at > 0) plru_reset();
    else if (ld || st) begin
      if (hw >= 0) begin
        touch(s, hw);
        if (st) m_dirty[s][hw] = 1;
      end else begin
        touch(s, vw);
        m_tag[s][vw] = t;
        m_val[s][vw] = 1;
        m_dirty[s][vw] = st;
        m_line[s][vw] = rline();
      end
    end
  endtask

  task automatic fill_set(input int s, input logic [19:0] base, input bit dirty0);
    for (int w = 0; w < 4; w++) begin
      m_tag[s][w] = base + 20'(w);
      m_val[s][w] = 1;
      m_dirty[s][w] = dirty0 && w == 0;
      m_line[s][w] = rline();
    end
  endtask

  initial begin
    for (int s = 0; s < 128; s++)
      for (int w = 0; w < 4; w++) begin
        m_tag[s][w] = 20'($urandom);
        m_val[s][w] = 0;
        m_dirty[s][w] = 0;
        m_line[s][w] = rline();
      end
    do_reset();
    #1;
    check("rst_ready", ReqReady, 1);
    check("rst_pulses", {HitAble, WriteBuffAble, MSHRAble, TagReadAble}, 4'b0);
    check("rst_fields", {HitWay, MSHRWay, WriteBackCnt, MSHRAddr}, 48'b0);
    // the one-cycle hit scenario on set 2
    m_val[2][2] = 1;
    m_tag[2][2] = 20'h00001;
    do_req(1, 0, 32'h0000_1040, 32'h0, 3'd1, 0, 0, 0);
    // cold store miss on set 5
    do_reset();
    do_req(0, 1, 32'h1234_50A4, 32'hDEAD_BEEF, 3'd4, 0, 0, 0);
    // dirty way0 eviction with fresh tree, then the same with a busy write buffer
    do_reset();
    fill_set(5, 20'hABCDE, 1);
    do_req(1, 0, 32'h1111_10A8, 32'h0, 3'd2, 0, 0, 0);
    check("evict_way0", obs_mway, 4'b0001);
    do_reset();
    fill_set(5, 20'hABCDE, 1);
    do_req(0, 1, 32'h2222_20A0, 32'h55AA_33CC, 3'd6, 3, 1, 0);
    // reset dropped in ALLOC and in EVICT
    do_req(1, 0, 32'h3333_3100, 32'h0, 3'd3, 0, 5, 3);
    fill_set(9, 20'h00777, 1);
    do_req(1, 0, 32'h4444_4120, 32'h0, 3'd5, 5, 0, 3);
    // four misses to a full clean set walk the tree
    do_reset();
    fill_set(9, 20'h00100, 0);
    for (int i = 0; i < 4; i++) begin
      do_req(1, 0, {20'h00200 + 20'(i), 7'd9, 5'd0}, 32'h0, 3'(i), 0, 0, 0);
      check("plru_seq", obs_mway, seq[i]);
    end
    // duplicate tags resolve to the lowest way; neither-kind request is silent
    m_val[7][1] = 1; m_tag[7][1] = 20'h0BEEF;
    m_val[7][3] = 1; m_tag[7][3] = 20'h0BEEF;
    do_req(0, 1, {20'h0BEEF, 7'd7, 5'd4}, 32'h1, 3'd7, 0, 0, 0);
    do_req(0, 0, {20'h0BEEF, 7'd7, 5'd0}, 32'h2, 3'd0, 0, 0, 0);
    do_req(0, 0, 32'h9999_9000, 32'h3, 3'd1, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 6; i++) pool[i] = 20'($urandom);
    for (int i = 0; i < 250; i++) begin
      int r;
      r = int'($urandom_range(0, 7));
      do_req(r > 3, r inside {[1:3]}, {pool[$urandom_range(0, 5)], 7'(sets[$urandom_range(0, 3)]), 5'($urandom)},
             $urandom, 3'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_stage1.md
DCACHE_STAGE1 -- requirements
Module: dcache_stage1

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of ways (fixed 4; one-hot way outputs are 4 bits).
REQ-002 SHALL have parameter SETS, default 128, number of sets; index is 7 bits, offset 5 bits (32-byte line), tag 20 bits.
REQ-003 SHALL have the following ports (name  direction  width  meaning):
- Clk  in  1  sole clock, rising edge.
- Rest  in  1  synchronous, active-high reset.
- ReqValid  in  1  LSU request valid.
- ReqReady  out  1  block can accept a request.
- ReqLoad  in  1  request is a load.
- ReqStore  in  1  request is a store.
- ReqAddr  in  32  byte address.
- ReqStoreData  in  32  store data.
- ReqPtr  in  3  LSU queue pointer.
- TagReadAble  out  1  tag/data RAM read strobe.
- TagReadIndex  out  7  RAM read index.
- TagRdTag  in  80  way tags, way0 in [19:0].
- TagRdValid  in  4  per-way valid.
- TagRdDirty  in  4  per-way dirty.
- LineRdData  in  1024  per-way line, way0 in [255:0].
- HitAble  out  1  hit pulse.
- HitWay  out  4  one-hot hit way.
- HitIndex  out  7  hit set.
- HitLoad  out  1  hit is a load.
- HitStore  out  1  hit is a store.
- HitPtr  out  3  hit pointer.
- WriteBuffAble  out  1  victim push pulse.
- WriteBuffAddr  out  32  victim line address.
- WriteBackDate  out  256  victim line.
- WriteBackCnt  out  8  word mask.
- WriteBuffFull  in  1  write buffer cannot accept.
- MSHRAble  out  1  miss allocate pulse.
- MSHRAddr  out  32  line-aligned miss address.
- MSHRLoad  out  1  miss is a load.
- MSHRStore  out  1  miss is a store.
- MSHRStoreTemp  out  32  store data.
- MSHRWay  out  4  one-hot refill way.
- MSHRPtr  out  3  miss pointer.
- MSHRFull  in  1  MSHR cannot accept.

Function
REQ-004 FSM states: IDLE, LOOKUP, EVICT, ALLOC; ReqReady = 1 only in IDLE.
REQ-005 Accept on ReqValid & ReqReady: latch Load/Store/Addr/Data/Ptr; TagReadAble = ReqValid in IDLE, combinational, with TagReadIndex = ReqAddr[11:5]; next state LOOKUP.
REQ-006 RAM read latency is exactly 1 cycle; Tag*/LineRdData are sampled only in LOOKUP.
REQ-007 Hit = TagRdValid[w] & (tag[w] == latched Addr[31:12]); multiple hits resolve to the lowest way.
REQ-008 Hit in LOOKUP: HitAble pulses for 1 cycle on the next cycle with HitWay/HitIndex/HitLoad/HitStore/HitPtr; PLRU updates; next state IDLE.
REQ-009 Miss victim selection: lowest-index invalid way, else the PLRU way; latch victim way, tag, dirty and line.
REQ-010 Miss with valid & dirty victim goes to EVICT; otherwise it goes to ALLOC.
REQ-011 EVICT: wait while WriteBuffFull = 1; otherwise pulse WriteBuffAble 1 cycle with WriteBuffAddr = {victim tag, index, 5'b0}, WriteBackDate = victim line, WriteBackCnt = 8'hFF; next state ALLOC.
REQ-012 ALLOC: wait while MSHRFull = 1; otherwise pulse MSHRAble 1 cycle with MSHRAddr = {Addr[31:5], 5'b0}, MSHRWay = victim one-hot, and request fields; update PLRU to the victim way; next state IDLE.
REQ-013 PLRU: 3 bits {b2,b1,b0} per set. Victim = b0 ? (b2 ? way3 : way2) : (b1 ? way1 : way0). On access to way w: b0 <= (w < 2); if w < 2 then b1 <= ~w[0], else b2 <= ~w[0].
REQ-014 A request with neither Load nor Store is accepted and produces no output pulse.
REQ-015 All pulse outputs SHALL be registered and never asserted for more than one consecutive cycle per request.

Reset
REQ-016 Rest SHALL force IDLE, all PLRU bits to 0, and all outputs to 0 except ReqReady = 1, including when Rest is asserted mid-EVICT or mid-ALLOC (the pending request is dropped).

Structure
REQ-017 Tag/index/offset widths, FSM encodings and WAYS/SETS SHALL live in the shared define file.
REQ-018 The PLRU array SHALL be a sub-module, dcache_plru (read port for victim select, write port for update).

Verification
REQ-019 Load to 0x0000_1040 with way2 valid, tag 0x00001 -> HitAble pulses 2 cycles after accept, HitWay = 4'b0100, HitIndex = 7'd2.
REQ-020 After reset, store miss to set 5 with all ways invalid -> no WriteBuffAble; MSHRAble with MSHRWay = 4'b0001 and MSHRAddr line-aligned.
REQ-021 Set full, PLRU = 0, way0 dirty with tag 0xABCDE -> WriteBuffAble with WriteBuffAddr = 0xABCDE0A0 (set 5), then MSHRAble on the following cycle with MSHRWay = 4'b0001.
REQ-022 WriteBuffFull held for 3 cycles in EVICT -> WriteBuffAble delayed 3 cycles; ReqReady stays 0.
REQ-023 Rest asserted in ALLOC with MSHRFull = 1 -> next cycle IDLE, ReqReady = 1, no MSHRAble.
REQ-024 Four consecutive misses to one full clean set -> victims way0, way2, way1, way3.
